// File: rtl/grid_sampler.sv
// Maps pen samples onto a ROWS x COLS grid of saturating intensities; streams cells row-major on request.
// Latency: cell update col+row+3 edges after sample accept; stream valid one edge after frame_req, N beats.
// Backpressure: sample_ready low while busy or on clear/frame_req; stream holds out_data/out_index while !out_ready.
module grid_sampler #(
  parameter int X0      = 89,
  parameter int Y0      = 33,
  parameter int CELL_W  = 20,
  parameter int CELL_H  = 28,
  parameter int COLS    = 7,
  parameter int ROWS    = 7,
  parameter int LEVEL_W = 2,
  parameter int COORD_W = 9,
  localparam int N      = ROWS * COLS,
  localparam int IDX_W  = $clog2(N),
  localparam int CNT_W  = $clog2(N + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [COORD_W-1:0] sample_x,
  input  logic [COORD_W-1:0] sample_y,
  input  logic               pen,
  input  logic               frame_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic [N-1:0]       grid_bits,
  output logic [CNT_W-1:0]   cell_count,
  output logic               busy
);

  localparam int CW1   = COORD_W + 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW1-1:0]     X_LO    = CW1'(X0);
  localparam logic [CW1-1:0]     X_HI    = CW1'(X0 + COLS * CELL_W);
  localparam logic [CW1-1:0]     Y_LO    = CW1'(Y0);
  localparam logic [CW1-1:0]     Y_HI    = CW1'(Y0 + ROWS * CELL_H);
  localparam logic [CW1-1:0]     CW_C    = CW1'(CELL_W);
  localparam logic [CW1-1:0]     CH_C    = CW1'(CELL_H);
  localparam logic [IDX_W-1:0]   COLS_I  = IDX_W'(COLS);
  localparam logic [IDX_W-1:0]   LAST_I  = IDX_W'(N - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

  typedef enum logic [2:0] {IDLE, DIVX, DIVY, UPDATE, STREAM} state_t;

  state_t             state;
  logic [CW1-1:0]     rx, ry;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [LEVEL_W-1:0] cells [N];

  logic [CW1-1:0]   x_ext, y_ext;
  logic             in_grid;
  logic [IDX_W-1:0] upd_idx;

  // Extra top bit keeps the range compare and the offset subtraction from wrapping.
  assign x_ext   = {1'b0, sample_x};
  assign y_ext   = {1'b0, sample_y};
  assign in_grid = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign upd_idx = IDX_W'(row) * COLS_I + IDX_W'(col);

  assign sample_ready = (state == IDLE) && !clear && !frame_req;
  assign busy         = (state != IDLE);
  assign out_last     = out_valid && (out_index == LAST_I);
  assign out_data     = out_valid ? cells[out_index] : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rx         <= '0;
      ry         <= '0;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      grid_bits  <= '0;
      cell_count <= '0;
      for (int i = 0; i < N; i++) cells[i] <= '0;
    end else if (clear) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_index  <= '0;
      grid_bits  <= '0;
      cell_count <= '0;
      for (int i = 0; i < N; i++) cells[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_req) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            out_index <= '0;
          end else if (sample_valid && pen && in_grid) begin
            rx    <= x_ext - X_LO;
            ry    <= y_ext - Y_LO;
            col   <= '0;
            row   <= '0;
            state <= DIVX;
          end
        end
        DIVX: begin
          if (rx >= CW_C) begin
            rx  <= rx - CW_C;
            col <= col + COL_W'(1);
          end else begin
            state <= DIVY;
          end
        end
        DIVY: begin
          if (ry >= CH_C) begin
            ry  <= ry - CH_C;
            row <= row + ROW_W'(1);
          end else begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (cells[upd_idx] != LVL_MAX) cells[upd_idx] <= cells[upd_idx] + LEVEL_W'(1);
          if (cells[upd_idx] == '0) cell_count <= cell_count + CNT_W'(1);
          grid_bits[upd_idx] <= 1'b1;
          state <= IDLE;
        end
        STREAM: begin
          if (out_ready) begin
            if (out_index == LAST_I) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_index <= '0;
            end else begin
              out_index <= out_index + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_sampler.sv
// Randomized and directed bench for grid_sampler against a cell-array reference model.
module tb_grid_sampler;
  localparam int N = 49;

  logic        clock = 1'b0;
  logic        resetn, clear, sample_valid, sample_ready, pen, frame_req;
  logic [8:0]  sample_x, sample_y;
  logic        out_valid, out_ready, out_last, busy;
  logic [1:0]  out_data;
  logic [5:0]  out_index;
  logic [48:0] grid_bits;
  logic [5:0]  cell_count;

  int checks = 0;
  int failures = 0;
  int lvl [N];
  int cnt_m;

  always #5 clock = ~clock;

  grid_sampler dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_x(sample_x), .sample_y(sample_y), .pen(pen),
    .frame_req(frame_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .grid_bits(grid_bits), .cell_count(cell_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] model_bits();
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < N; i++) if (lvl[i] != 0) b[i] = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) lvl[i] = 0;
    cnt_m = 0;
  endtask

  task automatic check_grid(input string tag);
    chk({tag, "_bits"}, 64'(grid_bits), model_bits());
    chk({tag, "_count"}, 64'(cell_count), 64'(cnt_m));
  endtask

  task automatic send(input int x, input int y, input bit p);
    int  n, col, row, idx;
    bit  hit;
    hit = p && x >= 89 && x < 89 + 7 * 20 && y >= 33 && y < 33 + 7 * 28;
    n = 0;
    while (!sample_ready && n < 100) begin tick(); n++; end
    chk("ready_wait", 64'(sample_ready), 64'd1);
    sample_valid = 1'b1;
    sample_x = 9'(x);
    sample_y = 9'(y);
    pen = p;
    tick();
    sample_valid = 1'b0;
    if (hit) begin
      col = (x - 89) / 20;
      row = (y - 33) / 28;
      idx = row * 7 + col;
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk("latency", 64'(n), 64'(col + row + 3));
      if (lvl[idx] == 0) cnt_m++;
      if (lvl[idx] < 3) lvl[idx]++;
    end else begin
      chk("discard_idle", 64'(busy), 64'd0);
    end
    chk("ready_back", 64'(sample_ready), 64'd1);
    check_grid("sample");
  endtask

  // mode 0: ready held high, 1: toggling 1,0,1,0..., 2: random
  task automatic read_frame(input int mode);
    int idx, t;
    bit r;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    chk("stream_start", 64'(out_valid), 64'd1);
    idx = 0;
    t = 0;
    while (idx < N && t < 1000) begin
      chk("beat_valid", 64'(out_valid), 64'd1);
      chk("beat_index", 64'(out_index), 64'(idx));
      chk("beat_data", 64'(out_data), 64'(lvl[idx]));
      chk("beat_last", 64'(out_last), 64'(idx == N - 1));
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      out_ready = r;
      tick();
      if (r) idx++;
      t++;
    end
    out_ready = 1'b0;
    chk("stream_beats", 64'(idx), 64'(N));
    chk("stream_end_valid", 64'(out_valid), 64'd0);
    chk("stream_end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    resetn = 1'b0; clear = 1'b0; sample_valid = 1'b0; pen = 1'b0;
    frame_req = 1'b0; out_ready = 1'b0; sample_x = '0; sample_y = '0;
    model_clear();
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    check_grid("rst");
    tick();
    resetn = 1'b1;
    tick();
    chk("rst_ready", 64'(sample_ready), 64'd1);

    // Cell mapping at both grid corners
    send(89, 33, 1'b1);
    send(228, 228, 1'b1);

    // Out of range and pen up
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    check_grid("clear");
    send(229, 100, 1'b1);
    send(88, 100, 1'b1);
    send(100, 229, 1'b1);
    send(100, 100, 1'b0);

    // Saturation on cell 0
    for (int k = 0; k < 5; k++) begin
      send(95, 40, 1'b1);
      chk("sat_level", 64'(lvl[0]), 64'(k < 3 ? k + 1 : 3));
      read_frame(0);
    end

    // Streaming with alternating ready
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    send(89, 33, 1'b1);
    send(149, 117, 1'b1);
    read_frame(1);

    // frame_req and sample in the same cycle: stream wins, sample dropped
    frame_req = 1'b1; sample_valid = 1'b1; sample_x = 9'd200; sample_y = 9'd200; pen = 1'b1;
    #1;
    chk("simul_ready", 64'(sample_ready), 64'd0);
    tick();
    frame_req = 1'b0; sample_valid = 1'b0;
    chk("simul_stream", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 200) begin tick(); n++; end
    out_ready = 1'b0;
    chk("drain_len", 64'(n), 64'(N));
    chk("drain_busy", 64'(busy), 64'd0);
    check_grid("simul");

    // clear together with frame_req
    clear = 1'b1; frame_req = 1'b1; tick(); clear = 1'b0; frame_req = 1'b0; model_clear();
    chk("clrframe_valid", 64'(out_valid), 64'd0);
    chk("clrframe_busy", 64'(busy), 64'd0);
    check_grid("clrframe");

    // clear aborts a stream at index 10
    send(189, 60, 1'b1);
    frame_req = 1'b1; tick(); frame_req = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (out_index != 6'd10 && n < 100) begin tick(); n++; end
    chk("abort_at10", 64'(out_index), 64'd10);
    clear = 1'b1; out_ready = 1'b0;
    tick();
    clear = 1'b0; model_clear();
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    check_grid("abort");

    // resetn pulsed during DIVX
    sample_valid = 1'b1; sample_x = 9'd228; sample_y = 9'd228; pen = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    chk("divx_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    check_grid("mid_rst");
    tick();
    resetn = 1'b1;
    tick();
    check_grid("post_rst");
    read_frame(0);

    // Random samples against the model
    for (int k = 0; k < 40; k++)
      send($urandom_range(80, 240), $urandom_range(20, 240), 1'($urandom_range(0, 3) != 0));
    read_frame(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/grid_sampler.md
# grid_sampler

Parametrised successor to the fixed 7x7 binary image decoder between the PS/2 mouse tracker and the predictor. Maps pen samples in screen coordinates onto a configurable ROWS x COLS cell grid via a sequential subtract-divider and keeps a saturating multi-level intensity per cell. Exposes both a flat occupancy vector, backward compatible with the binary predictor input, and a ready/valid row-major stream of cell intensities for a greyscale predictor.

## Interface
- `X0`, default 89: grid left edge, in pixels.
- `Y0`, default 33: grid top edge, in pixels.
- `CELL_W`, default 20: cell width, in pixels.
- `CELL_H`, default 28: cell height, in pixels.
- `COLS`, default 7: grid columns.
- `ROWS`, default 7: grid rows.
- `LEVEL_W`, default 2: bits of intensity per cell.
- `COORD_W`, default 9: width of the input coordinates.
- Derived: N = ROWS*COLS; IDX_W = clog2(N); CNT_W = clog2(N+1).

Ports:
- `clock`  in  1: single clock for all state.
- `resetn`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous clear pulse (user erase).
- `sample_valid`  in  1: sample_x/sample_y/pen are valid.
- `sample_ready`  out  1: sample accepted on valid&ready.
- `sample_x`, `sample_y`  in  COORD_W: pen position in pixels.
- `pen`  in  1: pen down (left click).
- `frame_req`  in  1: pulse that starts a readout stream.
- `out_valid`  out  1: stream data valid.
- `out_ready`  in  1: stream consumer ready.
- `out_data`  out  LEVEL_W: intensity of cell out_index.
- `out_index`  out  IDX_W: row*COLS+col.
- `out_last`  out  1: high with the final stream element.
- `grid_bits`  out  N: bit i = (cell i != 0).
- `cell_count`  out  CNT_W: number of nonzero cells.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, DIVX, DIVY, UPDATE, STREAM.
- Priority is clear, then frame_req, then sample.
- **clear**, in any state: all cells go to 0, cell_count goes to 0, the state goes to IDLE, and out_valid drops on the next edge. Any in-progress divide or stream is aborted.
- **IDLE**:
  - sample_ready = !clear && !frame_req.
  - frame_req with no clear: go to STREAM with out_index = 0.
  - Accepted sample with pen=1 and inside the grid: latch rx = x-X0, ry = y-Y0, zero col and row, go to DIVX.
  - Inside the grid means X0 <= x < X0+COLS*CELL_W and Y0 <= y < Y0+CELL_H*ROWS.
  - Accepted sample that is out of range or has pen=0: consumed and discarded; stay in IDLE.
- **DIVX**: if rx >= CELL_W, then rx -= CELL_W and col++, one step per cycle. Otherwise go to DIVY.
- **DIVY**: the same operation on ry/CELL_H/row. When done, go to UPDATE.
- **UPDATE**:
  - cell[row*COLS+col] is incremented, saturating at 2^LEVEL_W-1.
  - If the cell was 0, cell_count is incremented.
  - Go to IDLE.
- **STREAM**:
  - out_valid = 1, out_data = cell[out_index], out_last = (out_index == N-1).
  - On out_valid && out_ready: if out_last, go to IDLE with out_index = 0; otherwise out_index++.
  - sample_ready = 0 throughout; frame_req is ignored.
- grid_bits and cell_count are registered and reflect the cell array after every UPDATE and clear.
- Arithmetic: range compares and subtraction are done at COORD_W+1 bits, so no wrap occurs. col and row never exceed COLS-1 and ROWS-1.

## Timing
- Reset values:
  - All cells 0, grid_bits 0, cell_count 0.
  - State IDLE, out_valid 0, out_index 0, out_last 0, out_data 0, busy 0.
  - sample_ready 1 after resetn deasserts, assuming clear and frame_req are low.
- Sample latency: the accepting edge is edge 0. The cell, grid_bits and cell_count update on edge col+row+3.
- sample_ready returns high on the same edge as that update.
- Stream: out_valid rises on the edge after frame_req is accepted. A stream with out_ready held high takes exactly N cycles.
- out_data and out_index stay stable while out_valid && !out_ready.
- Asserting resetn low mid-divide or mid-stream returns all state to reset values immediately.

## Test plan
- Cell mapping: reset, then sample (89,33) pen=1. Cell 0 goes to 1, grid_bits = 1, cell_count = 1 on edge 3. Then sample (228,228): cell 48 goes to 1 on edge 15, cell_count = 2.
- Out of range and pen up: samples (229,100), (88,100) and (100,229), plus (100,100) with pen=0, leave grid_bits = 0, cell_count = 0 and busy low.
- Saturation: five samples at (95,40). Levels go 1,2,3,3,3. cell_count stays 1.
- Streaming: paint cells 0 and 24, then pulse frame_req with out_ready toggling 1,0,1,0…. Expect 49 beats with indices 0..48 in order, data 1 at indices 0 and 24 and 0 elsewhere, and out_last only at 48. Data is held while out_ready=0.
- Simultaneous events:
  - frame_req and sample_valid in the same IDLE cycle: the stream starts and the sample is not accepted (sample_ready = 0).
  - clear together with frame_req: nothing streams and all cells are 0.
- Abort: clear asserted at stream index 10 gives out_valid = 0 on the next edge and IDLE. Next, resetn pulsed low during DIVX of a (228,228) sample leaves all outputs at reset values and no cell updated.
